// File: rtl/krake_resp_uart_pkg.sv
// ---------------------------------------------------------------------------
// krake_resp_uart_pkg
// Shared definitions for the read-response UART: FSM state encodings, the
// default baud divisor, frame bit counts and the shift-register load helper.
//
// Optional feature macro: KRAKE_RESP_PARITY_EN
//   defined   -> 8E1-style frame with an even-parity bit (11 bit times)
//   undefined -> plain 8N1 frame (10 bit times)
// ---------------------------------------------------------------------------
package krake_resp_uart_pkg;

    typedef enum logic [2:0] {
        URT_IDLE   = 3'd0,
        URT_START  = 3'd1,
        URT_DATA   = 3'd2,
        URT_STOP   = 3'd3,
        URT_PARITY = 3'd4
    } urt_state_e;

    localparam int unsigned URT_DIV_DEFAULT = 434;
    localparam int unsigned URT_DATA_BITS   = 8;

`ifdef KRAKE_RESP_PARITY_EN
    localparam int unsigned URT_FRAME_BITS = 11;
    localparam int unsigned URT_SHIFT_W    = 9;
`else
    localparam int unsigned URT_FRAME_BITS = 10;
    localparam int unsigned URT_SHIFT_W    = 8;
`endif

    // The parity bit rides above the data byte so that, after eight right
    // shifts, it lands in bit 0 and the PARITY state can drive shift[0].
    function automatic logic [URT_SHIFT_W-1:0] frame_load(input logic [7:0] data);
`ifdef KRAKE_RESP_PARITY_EN
        return {^data, data};
`else
        return data;
`endif
    endfunction

endpackage

// File: rtl/krake_sync_fifo.sv
// ---------------------------------------------------------------------------
// krake_sync_fifo
// Parameterised single-clock FIFO with show-ahead read data.
//
// Parameters: WIDTH (data width), LOG2 (log2 of depth)
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous reset, active-low (pointers and count only)
//   push_i   write request; accepted when not full, or when full with pop_i
//   pop_i    read request; ignored when empty
//   wdata_i  write data
//   rdata_o  head-of-queue data, valid while empty_o=0
//   full_o   count == depth
//   empty_o  count == 0
//   count_o  occupancy, 0..depth
// ---------------------------------------------------------------------------
module krake_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LOG2  = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LOG2:0]    count_o
);

    localparam int unsigned DEPTH = 1 << LOG2;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LOG2:0]    count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign full_o  = (count_q == (LOG2+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head is leaving in the same
    // cycle; the write lands in the slot being vacated.
    assign wr_en = push_i & (~full_o | pop_i);
    assign rd_en = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only entries covered by the pointers are read.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/krake_resp_uart.sv
// ---------------------------------------------------------------------------
// krake_resp_uart
// Captures every completed Wishbone read byte (one per ACK rising edge on a
// read cycle) into a FIFO and serialises it LSB-first as a UART frame on the
// RX1 line.
//
// Parameters: CLK_DIV (clk_i cycles per bit, 4..65535), FIFO_LOG2 (log2 depth)
// Optional feature macro: KRAKE_RESP_PARITY_EN (adds an even-parity bit)
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous reset, active-low
//   ack_i       Wishbone ACK from the slave mux
//   we_i        Wishbone WE; only ACKs with we_i=0 are captured
//   dat_i       Wishbone read data, valid while ack_i=1
//   tx_o        registered UART output, idle high
//   busy_o      registered: frame in flight or FIFO non-empty
//   overflow_o  sticky: a read byte was dropped on a full FIFO
// ---------------------------------------------------------------------------
module krake_resp_uart
    import krake_resp_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = URT_DIV_DEFAULT,
    parameter int unsigned FIFO_LOG2 = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ack_i,
    input  logic       we_i,
    input  logic [7:0] dat_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       overflow_o
);

    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

    urt_state_e             state_q, state_d;
    logic [15:0]            baud_q, baud_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [URT_SHIFT_W-1:0] shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   ovf_q, ovf_d;
    logic                   ack_q;

    logic                   push;
    logic                   push_acc;
    logic                   fifo_pop;
    logic [7:0]             fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FIFO_LOG2:0]     fifo_count;
    logic [FIFO_LOG2:0]     count_nxt;
    logic                   baud_zero;

    // Rising-edge detect so a multi-cycle ACK yields a single capture.
    assign push     = ack_i & ~ack_q & ~we_i;
    assign push_acc = push & (~fifo_full | fifo_pop);

    krake_sync_fifo #(
        .WIDTH (8),
        .LOG2  (FIFO_LOG2)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_i),
        .push_i  (push),
        .pop_i   (fifo_pop),
        .wdata_i (dat_i),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign baud_zero = (baud_q == '0);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;

        case (state_q)
            URT_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = frame_load(fifo_rdata);
                    bit_idx_d = '0;
                    baud_d    = DIV_M1;
                    state_d   = URT_START;
                end
            end
            URT_START: begin
                if (baud_zero) begin
                    baud_d  = DIV_M1;
                    state_d = URT_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            URT_DATA: begin
                if (baud_zero) begin
                    baud_d  = DIV_M1;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
`ifdef KRAKE_RESP_PARITY_EN
                        state_d = URT_PARITY;
`else
                        state_d = URT_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`ifdef KRAKE_RESP_PARITY_EN
            URT_PARITY: begin
                if (baud_zero) begin
                    baud_d  = DIV_M1;
                    state_d = URT_STOP;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`endif
            URT_STOP: begin
                if (baud_zero) begin
                    // Chain straight into the next start bit when data waits.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_d   = frame_load(fifo_rdata);
                        bit_idx_d = '0;
                        baud_d    = DIV_M1;
                        state_d   = URT_START;
                    end else begin
                        state_d = URT_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                state_d = URT_IDLE;
                baud_d  = '0;
            end
        endcase

        // Outputs are derived from next-state values so the registered pins
        // change on the same edge as the state.
        case (state_d)
            URT_START:  tx_d = 1'b0;
            URT_DATA:   tx_d = shift_d[0];
            URT_PARITY: tx_d = shift_d[0];
            default:    tx_d = 1'b1;
        endcase

        count_nxt = fifo_count + (FIFO_LOG2+1)'(push_acc) - (FIFO_LOG2+1)'(fifo_pop);
        busy_d    = (state_d != URT_IDLE) | (count_nxt != '0);
        ovf_d     = ovf_q | (push & fifo_full & ~fifo_pop);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= URT_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            ack_q     <= ack_i;
        end
    end

    // Shift register holds data only; its content is irrelevant in IDLE.
    always_ff @(posedge clk_i) begin
        shift_q <= shift_d;
    end

    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_krake_resp_uart.sv
module tb_krake_resp_uart;

    localparam int DIV1 = 4;
    localparam int DIV2 = 100;
`ifdef KRAKE_RESP_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ack1 = 1'b0, we1 = 1'b0;
    logic [7:0] dat1 = 8'h00;
    logic       ack2 = 1'b0, we2 = 1'b0;
    logic [7:0] dat2 = 8'h00;
    logic       tx1, busy1, ovf1;
    logic       tx2, busy2, ovf2;
    logic       mon_sel = 1'b0;
    logic       tx_mon, busy_mon;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign tx_mon   = mon_sel ? tx2 : tx1;
    assign busy_mon = mon_sel ? busy2 : busy1;

    krake_resp_uart #(.CLK_DIV(DIV1), .FIFO_LOG2(4)) dut1 (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .ack_i      (ack1),
        .we_i       (we1),
        .dat_i      (dat1),
        .tx_o       (tx1),
        .busy_o     (busy1),
        .overflow_o (ovf1)
    );

    krake_resp_uart #(.CLK_DIV(DIV2), .FIFO_LOG2(4)) dut2 (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .ack_i      (ack2),
        .we_i       (we2),
        .dat_i      (dat2),
        .tx_o       (tx2),
        .busy_o     (busy2),
        .overflow_o (ovf2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bounded wait for a start bit on the monitored line.
    task automatic wait_start(input int budget, input string tag);
        int i;
        i = 0;
        while (tx_mon !== 1'b0 && i < budget) begin
            tick();
            i++;
        end
        check_eq(tag, {31'd0, tx_mon}, 32'd0);
    endtask

    // Called on the first cycle of a start bit; samples every cycle of the
    // frame and returns on the first cycle after the stop bit.
    task automatic rx_check(input int div, input logic [7:0] exp, input string tag);
        logic [10:0] bits;
        int          glitches;
        logic        busy_all;
        logic        fmt_ok;
        bits     = '0;
        glitches = 0;
        busy_all = 1'b1;
        for (int k = 0; k < FB; k++) begin
            for (int c = 0; c < div; c++) begin
                if (c == 0) bits[k] = tx_mon;
                else if (tx_mon !== bits[k]) glitches++;
                if (busy_mon !== 1'b1) busy_all = 1'b0;
                tick();
            end
        end
        check_eq({tag, "_data"}, {24'd0, bits[8:1]}, {24'd0, exp});
        fmt_ok = (bits[0] == 1'b0) && (bits[FB-1] == 1'b1) && (glitches == 0) && busy_all;
        check_eq({tag, "_fmt"}, {31'd0, fmt_ok}, 32'd1);
`ifdef KRAKE_RESP_PARITY_EN
        check_eq({tag, "_par"}, {31'd0, bits[9]}, {31'd0, ^exp});
`endif
    endtask

    // No activity on the monitored line/busy for a number of cycles.
    task automatic expect_quiet(input int cycles, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            if (tx_mon !== 1'b1 || busy_mon !== 1'b0) bad++;
            tick();
        end
        check_eq(tag, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx1", {31'd0, tx1}, 32'd1);
        check_eq("rst_busy1", {31'd0, busy1}, 32'd0);
        check_eq("rst_ovf1", {31'd0, ovf1}, 32'd0);
        check_eq("rst_tx2", {31'd0, tx2}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Single read 0xA5: start bit two cycles after ACK is sampled
        mon_sel = 1'b0;
        ack1 = 1'b1; we1 = 1'b0; dat1 = 8'hA5;
        tick();
        ack1 = 1'b0;
        check_eq("single_n1_tx", {31'd0, tx1}, 32'd1);
        check_eq("single_n1_busy", {31'd0, busy1}, 32'd1);
        tick();
        check_eq("single_n2_start", {31'd0, tx1}, 32'd0);
        rx_check(DIV1, 8'hA5, "single");
        check_eq("single_busy_fall", {31'd0, busy1}, 32'd0);
        check_eq("single_idle_tx", {31'd0, tx1}, 32'd1);
        expect_quiet(10, "single_after");

        // Held ACK for 5 cycles: exactly one frame
        ack1 = 1'b1; dat1 = 8'h3C;
        fork
            begin
                repeat (5) tick();
                ack1 = 1'b0;
            end
            begin
                tick();
                wait_start(10, "held_start");
                rx_check(DIV1, 8'h3C, "held");
            end
        join
        expect_quiet(60, "held_single_frame");

        // Write-cycle ACK is ignored
        ack1 = 1'b1; we1 = 1'b1; dat1 = 8'h5A;
        tick();
        ack1 = 1'b0; we1 = 1'b0;
        expect_quiet(30, "write_ignored");

        // Back-to-back reads two cycles apart: contiguous frames
        fork
            begin
                ack1 = 1'b1; dat1 = 8'h01; tick();
                ack1 = 1'b0; tick();
                ack1 = 1'b1; dat1 = 8'h02; tick();
                ack1 = 1'b0; tick();
                ack1 = 1'b1; dat1 = 8'h03; tick();
                ack1 = 1'b0;
            end
            begin
                tick();
                tick();
                check_eq("b2b_start", {31'd0, tx1}, 32'd0);
                rx_check(DIV1, 8'h01, "b2b0");
                rx_check(DIV1, 8'h02, "b2b1");
                rx_check(DIV1, 8'h03, "b2b2");
                check_eq("b2b_busy_120", {31'd0, busy1}, 32'd0);
            end
        join
        expect_quiet(20, "b2b_after");

        // Overflow on the slow instance: 18 reads, 0x11 is dropped
        mon_sel = 1'b1;
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    ack2 = 1'b1; dat2 = 8'(i);
                    tick();
                    if (i == 16) check_eq("ovf_before_18th", {31'd0, ovf2}, 32'd0);
                    if (i == 17) check_eq("ovf_after_18th", {31'd0, ovf2}, 32'd1);
                    ack2 = 1'b0;
                    tick();
                end
            end
            begin
                tick();
                tick();
                check_eq("ovf_start", {31'd0, tx2}, 32'd0);
                for (int i = 0; i < 17; i++) begin
                    rx_check(DIV2, 8'(i), $sformatf("ovf_byte%0d", i));
                end
            end
        join
        check_eq("ovf_sticky", {31'd0, ovf2}, 32'd1);
        check_eq("ovf_busy_done", {31'd0, busy2}, 32'd0);
        expect_quiet(300, "ovf_no_extra_frame");

        // Reset during data bit 3 of 0xFF
        mon_sel = 1'b0;
        ack1 = 1'b1; dat1 = 8'hFF;
        tick();
        ack1 = 1'b0;
        tick();
        check_eq("rstmid_start", {31'd0, tx1}, 32'd0);
        repeat (17) tick();
        check_eq("rstmid_busy_pre", {31'd0, busy1}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_tx_async", {31'd0, tx1}, 32'd1);
        check_eq("rstmid_busy_async", {31'd0, busy1}, 32'd0);
        check_eq("rstmid_ovf2_clr", {31'd0, ovf2}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        expect_quiet(60, "rstmid_no_frame");

`ifdef KRAKE_RESP_PARITY_EN
        // Parity frames: 0x07 -> parity 1, 0x03 -> parity 0, 11 bit times each
        fork
            begin
                ack1 = 1'b1; dat1 = 8'h07; tick();
                ack1 = 1'b0; tick();
                ack1 = 1'b1; dat1 = 8'h03; tick();
                ack1 = 1'b0;
            end
            begin
                tick();
                tick();
                check_eq("par_start", {31'd0, tx1}, 32'd0);
                rx_check(DIV1, 8'h07, "par07");
                rx_check(DIV1, 8'h03, "par03");
                check_eq("par_busy_done", {31'd0, busy1}, 32'd0);
            end
        join
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
